// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding,
// select codes and the rotating-priority pick function.
package rr_mux_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SEL_SRC0 = 2'b00;
    localparam logic [1:0] SEL_SRC1 = 2'b01;
    localparam logic [1:0] SEL_SRC2 = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    // Source 0 gets first priority after reset because the search starts at last+1.
    localparam logic [1:0] LAST_RESET = SEL_SRC2;

    // Search from last+1 upward modulo 3; returns SEL_NONE when nothing is pending.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = SEL_NONE;
        idx  = last;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == SEL_SRC2) ? SEL_SRC0 : idx + 2'd1;
            if (pick == SEL_NONE && req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [2:0] sel_to_gnt(input logic [1:0] sel);
        case (sel)
            SEL_SRC0: return 3'b001;
            SEL_SRC1: return 3'b010;
            SEL_SRC2: return 3'b100;
            default:  return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sel3_mux32.sv
// Combinational 3-input data mux; the "none" select code drives all zeros.
module sel3_mux32
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]       sel_i,
    input  logic [WIDTH-1:0] in0_i,
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        case (sel_i)
            SEL_SRC0: out_o = in0_i;
            SEL_SRC1: out_o = in1_i;
            SEL_SRC2: out_o = in2_i;
            default:  out_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Three-source round-robin arbiter with a registered mux select, a
// back-to-back re-arbitration path and a wrapping transfer counter.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [2:0]       gnt,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CNTW-1:0]  xfer_count
);

    state_e          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [2:0]      gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [1:0]      last_q, last_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            xfer;

    // out_valid is only ever high in GRANT, so out_ready is ignored elsewhere.
    assign xfer = valid_q & out_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                sel_d   = rr_pick(req, last_q);
                state_d = (sel_d == SEL_NONE) ? IDLE : GRANT;
            end
            GRANT: begin
                if (xfer) begin
                    // Transfer wins over a dropped request; rotate from the index just served.
                    last_d  = sel_q;
                    cnt_d   = cnt_q + CNTW'(1);
                    sel_d   = rr_pick(req, sel_q);
                    state_d = (sel_d == SEL_NONE) ? IDLE : GRANT;
                end else if (!req[sel_q]) begin
                    sel_d   = SEL_NONE;
                    state_d = IDLE;
                end
            end
            default: begin
                sel_d   = SEL_NONE;
                state_d = IDLE;
            end
        endcase

        gnt_d   = sel_to_gnt(sel_d);
        valid_d = (state_d == GRANT);
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= SEL_NONE;
            gnt_q   <= 3'b000;
            valid_q <= 1'b0;
            last_q  <= LAST_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    sel3_mux32 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel_i (sel_q),
        .in0_i (in1),
        .in1_i (in2),
        .in2_i (in3),
        .out_o (out_data)
    );

    assign gnt        = gnt_q;
    assign sel        = sel_q;
    assign out_valid  = valid_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: each step queues the expected
// post-edge outputs and retires them one edge later.
module tb_rr_mux_arbiter;

    localparam int WIDTH = 32;
    localparam int CNTW  = 16;

    localparam logic [31:0] D1 = 32'hAAAA_AAAA;
    localparam logic [31:0] D2 = 32'h5555_5555;
    localparam logic [31:0] D3 = 32'h3333_3333;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       req;
    logic [WIDTH-1:0] in1, in2, in3;
    logic             out_ready;
    logic [2:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [CNTW-1:0]  xfer_count;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [1:0]  sel;
        logic [31:0] data;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    rr_mux_arbiter #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .in1        (in1),
        .in2        (in2),
        .in3        (in3),
        .out_ready  (out_ready),
        .gnt        (gnt),
        .sel        (sel),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic rdy, input logic rs);
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        rst       = rs;
    endtask

    task automatic expect_next(input string tag, input logic [2:0] g, input logic [1:0] s,
                               input logic [31:0] d, input logic v, input logic [15:0] c);
        exp_t e;
        e.gnt   = g;
        e.sel   = s;
        e.data  = d;
        e.valid = v;
        e.cnt   = c;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic retire();
        exp_t  e;
        string t;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check({t, ".gnt"},   {29'd0, gnt},        {29'd0, e.gnt});
        check({t, ".sel"},   {30'd0, sel},        {30'd0, e.sel});
        check({t, ".data"},  out_data,            e.data);
        check({t, ".valid"}, {31'd0, out_valid},  {31'd0, e.valid});
        check({t, ".count"}, {16'd0, xfer_count}, {16'd0, e.cnt});
    endtask

    task automatic step(input string tag, input logic [2:0] r, input logic rdy, input logic rs,
                        input logic [2:0] g, input logic [1:0] s, input logic [31:0] d,
                        input logic v, input logic [15:0] c);
        drive(r, rdy, rs);
        expect_next(tag, g, s, d, v, c);
        retire();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req       = 3'b000;
        out_ready = 1'b0;
        in1       = D1;
        in2       = D2;
        in3       = D3;

        // Reset held for two edges
        step("rst0", 3'b000, 1'b0, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        step("rst1", 3'b000, 1'b0, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);

        // Single source, request dropped in the transfer cycle
        step("single_gnt",  3'b010, 1'b1, 1'b0, 3'b010, 2'b01, D2,    1'b1, 16'd0);
        step("single_done", 3'b000, 1'b1, 1'b0, 3'b000, 2'b11, 32'h0, 1'b0, 16'd1);

        // Round robin with all requests held, from a fresh pointer
        step("rr_rst", 3'b000, 1'b0, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        step("rr0",    3'b111, 1'b1, 1'b0, 3'b001, 2'b00, D1,    1'b1, 16'd0);
        step("rr1",    3'b111, 1'b1, 1'b0, 3'b010, 2'b01, D2,    1'b1, 16'd1);
        step("rr2",    3'b111, 1'b1, 1'b0, 3'b100, 2'b10, D3,    1'b1, 16'd2);
        step("rr3",    3'b111, 1'b1, 1'b0, 3'b001, 2'b00, D1,    1'b1, 16'd3);
        step("rr_end", 3'b000, 1'b1, 1'b0, 3'b000, 2'b11, 32'h0, 1'b0, 16'd4);

        // Backpressure then abandon; pointer must stay where reset put it
        step("bp_rst", 3'b000, 1'b0, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++)
            step($sformatf("bp%0d", i), 3'b100, 1'b0, 1'b0, 3'b100, 2'b10, D3, 1'b1, 16'd0);
        step("abandon",       3'b000, 1'b0, 1'b0, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        step("after_abandon", 3'b111, 1'b0, 1'b0, 3'b001, 2'b00, D1,    1'b1, 16'd0);

        // Reset with out_ready high while granted: no transfer counted
        step("rst_mid",  3'b111, 1'b1, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        step("post_rst", 3'b000, 1'b1, 1'b0, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);

        // Counter wrap: one grant edge plus 65535 transfer edges reaches FFFF
        step("wrap_rst", 3'b000, 1'b0, 1'b1, 3'b000, 2'b11, 32'h0, 1'b0, 16'd0);
        drive(3'b111, 1'b1, 1'b0);
        repeat (65535) @(posedge clk);
        expect_next("wrap_ffff", 3'b001, 2'b00, D1, 1'b1, 16'hFFFF);
        retire();
        expect_next("wrap_zero", 3'b010, 2'b01, D2, 1'b1, 16'h0000);
        retire();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of each source and of the output.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the width of the transfer counter.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port req, input, 3 bits, where req[i] high means source i has a word pending.
REQ-006 The block SHALL have ports in1, in2, in3, input, WIDTH bits each, carrying source 0, 1 and 2 data.
REQ-007 The block SHALL have port out_ready, input, 1 bit, the sink accept signal.
REQ-008 The block SHALL have port gnt, output, 3 bits, a one-hot grant, or zero when no grant is active.
REQ-009 The block SHALL have port sel, output, 2 bits, the registered mux select: 00 selects in1, 01 selects in2, 10 selects in3, 11 selects none.
REQ-010 The block SHALL have port out_data, output, WIDTH bits, the selected source word.
REQ-011 The block SHALL have port out_valid, output, 1 bit, high while a grant is active.
REQ-012 The block SHALL have port xfer_count, output, CNTW bits, counting completed transfers.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT; gnt, sel and out_valid SHALL be registered outputs of this FSM.
REQ-014 In IDLE with req==000, the FSM SHALL stay in IDLE with gnt=000, sel=11 and out_valid=0.
REQ-015 In IDLE with any req bit set, the FSM SHALL enter GRANT on the next edge with the winner selected by rotating priority; grant latency is 1 cycle from req sampled high.
REQ-016 Rotating priority SHALL search from index last+1 upward, modulo 3, where last is the index most recently served.
REQ-017 A transfer SHALL occur in any cycle where out_valid=1 and out_ready=1.
REQ-018 On a transfer, the block SHALL set last to the granted index, increment xfer_count (wrapping from all-ones to 0), and re-arbitrate in the same cycle using the current req.
  - If any req bit is set, the FSM SHALL stay in GRANT with the new winner on the next edge, with no bubble.
  - Otherwise the FSM SHALL return to IDLE.
REQ-019 A requester that keeps req high through its own transfer cycle SHALL be treated as having another word pending; with rotation it wins only if no other req is set.
REQ-020 In GRANT without a transfer, gnt and sel SHALL hold stable while req[granted] stays high.
REQ-021 In GRANT without a transfer, if req[granted] drops, the grant SHALL be abandoned: the FSM goes to IDLE next edge, last is unchanged, and xfer_count is unchanged.
REQ-022 When the same cycle has a transfer and req[granted]=0, the transfer SHALL take precedence and be counted.
REQ-023 out_data SHALL be combinational from sel: in1, in2 or in3 per sel, and all-zero when sel=11.
REQ-024 Sources SHALL hold data stable while granted.
REQ-025 Fairness: any requester holding req high SHALL be granted within 3 transfers.
REQ-026 out_ready SHALL be ignored while out_valid=0.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE, gnt=000, sel=11, out_valid=0, last=2 (so source 0 has first priority) and xfer_count=0; out_data SHALL follow sel and read 0.
REQ-028 A reset asserted during GRANT SHALL drop the grant without counting the transfer, even if out_ready=1 in that cycle.

Structure
REQ-029 A shared package SHALL hold the state encoding (IDLE, GRANT) and the select constants SEL_SRC0=00, SEL_SRC1=01, SEL_SRC2=10 and SEL_NONE=11.
REQ-030 The datapath SHALL be one sub-module, sel3_mux32, a combinational WIDTH-bit 3-input mux with zero output for sel=11, instantiated once.
REQ-031 The FSM, rotation pointer and counter SHALL reside in rr_mux_arbiter.

Verification
REQ-032 The bench SHALL cover reset: rst high 2 cycles with in1=AAAAAAAA -> sel=11, gnt=000, out_valid=0, out_data=00000000, xfer_count=0.
REQ-033 The bench SHALL cover a single source: req=010, in2=55555555, out_ready=1 -> one cycle later gnt=010, sel=01, out_data=55555555; req dropped after the transfer -> xfer_count=1, FSM in IDLE.
REQ-034 The bench SHALL cover round-robin: req=111 held, out_ready=1 -> grants 001,010,100,001 on consecutive cycles with no bubble, xfer_count=4.
REQ-035 The bench SHALL cover backpressure and abandon: req=100, out_ready=0 for 5 cycles -> gnt=100 and sel=10 stable; then req=000 -> IDLE next cycle, xfer_count unchanged, and the next req=111 grants 001.
REQ-036 The bench SHALL cover wrap: preload xfer_count=FFFF by 65535 transfers, then one more transfer -> xfer_count=0000.
REQ-037 The bench SHALL cover reset mid-grant: gnt=001, out_ready=1 and rst=1 in the same cycle -> next cycle gnt=000, xfer_count unchanged.
